// File: rtl/serial_sub.sv
// Bit-serial A - B - bin, LSB first, one full-subtractor cell with registered borrow; start->done latency WIDTH cycles.
// No backpressure: start is taken only in IDLE and ignored while busy; results hold until the next completion.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb, b_msb;

  logic             d, br_nxt, last;
  logic [WIDTH-1:0] r_nxt;

  assign last   = (cnt == CW'(WIDTH - 1));
  assign d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);
  assign r_nxt  = {d, r_sr[WIDTH-1:1]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_sr  <= a;
        b_sr  <= b;
        r_sr  <= '0;
        br    <= bin;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (state == SHIFT) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        r_sr <= r_nxt;
        br   <= br_nxt;
        cnt  <= cnt + 1'b1;
        // On the final bit d is the result MSB, so overflow is decided here.
        if (last) begin
          diff <= r_nxt;
          bout <= br_nxt;
          zero <= (r_nxt == '0);
          ovf  <= (a_msb ^ b_msb) & (a_msb ^ d);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub against an arithmetic reference model (WIDTH 8 and exhaustive WIDTH 4).
module tb_serial_sub;

  logic       clk, rst;
  logic       start8, bin8, busy8, done8, bout8, zero8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4, zero4, ovf4;
  logic [3:0] a4, b4, diff4;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] prev_diff;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4), .ovf(ovf4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  function automatic void model(input int w, input int ai, input int bi, input int bini,
                                output int d, output int bo, output int ov, output int z);
    int m, sa, sb, sr;
    m  = (1 << w) - 1;
    d  = (ai - bi - bini) & m;
    bo = (ai < bi + bini) ? 1 : 0;
    sa = (ai >= (1 << (w - 1))) ? ai - (1 << w) : ai;
    sb = (bi >= (1 << (w - 1))) ? bi - (1 << w) : bi;
    sr = sa - sb - bini;
    ov = (sr < -(1 << (w - 1)) || sr > (1 << (w - 1)) - 1) ? 1 : 0;
    z  = (d == 0) ? 1 : 0;
  endfunction

  // Accepts on the next edge, scrambles inputs afterwards, checks latency, hold, results and pulse width.
  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic bini);
    int ed, eb, eo, ez, cyc;
    logic seen;
    model(8, ai, bi, bini, ed, eb, eo, ez);
    a8 = ai; b8 = bi; bin8 = bini; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    check("busy_after_accept", busy8, 1);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 24) begin
      @(posedge clk); #1;
      cyc++;
      if (done8) seen = 1'b1;
      else check("diff_hold", diff8, prev_diff);
    end
    check("latency", cyc, 8);
    check("diff", diff8, ed);
    check("bout", bout8, eb);
    check("zero", zero8, ez);
    check("ovf", ovf8, eo);
    prev_diff = ed[7:0];
    @(posedge clk); #1;
    check("done_pulse_end", done8, 0);
    check("busy_end", busy8, 0);
  endtask

  task automatic run4(input logic [3:0] ai, input logic [3:0] bi, input logic bini);
    int ed, eb, eo, ez, cyc;
    model(4, ai, bi, bini, ed, eb, eo, ez);
    a4 = ai; b4 = bi; bin4 = bini; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    cyc = 0;
    while (!done4 && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w4_latency", cyc, 4);
    check("w4_diff", diff4, ed);
    check("w4_bout", bout4, eb);
    check("w4_zero", zero4, ez);
    check("w4_ovf", ovf4, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, ed, eb, eo, ez;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    prev_diff = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_flags", {bout8, zero8, ovf8}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases; every run starts immediately, so each accept is back-to-back at E_WIDTH+2.
    run8(8'h05, 8'h03, 1'b0);
    run8(8'h03, 8'h05, 1'b0);
    run8(8'h00, 8'h00, 1'b1);
    run8(8'h2A, 8'h2A, 1'b0);
    run8(8'h80, 8'h01, 1'b0);
    run8(8'h7F, 8'hFF, 1'b1);

    // start pulses during SHIFT and DONE, operands changing throughout.
    model(8, 8'h9C, 8'h37, 1, ed, eb, eo, ez);
    a8 = 8'h9C; b8 = 8'h37; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    n = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (done8) begin
        n++;
        check("robust_diff", diff8, ed);
        check("robust_bout", bout8, eb);
        check("robust_ovf", ovf8, eo);
      end
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      start8 = (c == 8) ? 1'b1 : ((c < 8) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    check("robust_done_count", n, 1);
    check("robust_idle", busy8, 0);
    prev_diff = ed[7:0];

    // Asynchronous reset after bit 3 of an operation.
    a8 = 8'h55; b8 = 8'h0F; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_diff", diff8, 0);
    check("midrst_flags", {bout8, zero8, ovf8}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) n++;
    end
    check("midrst_no_done", n, 0);
    prev_diff = '0;
    run8(8'h10, 8'h01, 1'b0);

    repeat (20) run8(8'($urandom), 8'($urandom), 1'($urandom));

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          run4(4'(ai), 4'(bi), 1'(ci));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
